// File: rtl/button_debouncer_if.sv
// Signal bundle between a raw push-button pin and its debounced outputs.
// The master side drives the pin. The slave side (the debouncer) drives the clean level, the pulses and busy.
interface button_debouncer_if;
  logic button_raw;
  logic button_level;
  logic press_pulse;
  logic release_pulse;
  logic busy;

  modport master (
    output button_raw,
    input  button_level,
    input  press_pulse,
    input  release_pulse,
    input  busy
  );

  modport slave (
    input  button_raw,
    output button_level,
    output press_pulse,
    output release_pulse,
    output busy
  );
endinterface

// File: rtl/button_debouncer.sv
// Debounces one bouncy push-button into a clean level plus single-cycle press/release pulses.
// Every bounce seen during a timing window aborts that window, and the next candidate is timed from zero.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 30000000,
  parameter int CNT_WIDTH       = 26
) (
  input logic             clock,
  input logic             reset,
  button_debouncer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 sync1;
  logic                 sync2;
  logic                 level;
  logic                 press;
  logic                 release_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.button_raw;
      sync2 <= sync1;
    end
  end

  // The count is exact-equality compared, so it stops at DEBOUNCE_CYCLES-1 and never wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      level     <= 1'b0;
      press     <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press     <= 1'b0;
      release_q <= 1'b0;
      case (state)
        IDLE: begin
          if (sync2) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!sync2) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync2) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            level     <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.button_level  = level;
  assign bus.press_pulse   = press;
  assign bus.release_pulse = release_q;
  assign bus.busy          = (state == PRESS_WAIT) || (state == RELEASE_WAIT);

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised and directed bench for button_debouncer, with a run-length reference model and a pulse scoreboard.
// A second instance with the default parameters checks that a long hold stays in the timing window.
module tb_button_debouncer;

  localparam int DEB = 4;

  typedef struct {
    bit is_press;
    int cycle;
  } event_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  button_debouncer_if bus_main ();
  button_debouncer_if bus_big ();

  button_debouncer #(.DEBOUNCE_CYCLES(DEB), .CNT_WIDTH(3)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_main)
  );

  button_debouncer dut_big (
    .clock(clock),
    .reset(reset),
    .bus  (bus_big)
  );

  always #5 clock = ~clock;

  int     checks = 0;
  int     errors = 0;
  int     cycle_cnt = 0;
  int     press_count = 0;
  int     release_count = 0;
  int     last_press_cycle = -1;
  int     last_release_cycle = -1;
  int     big_press_count = 0;
  event_t exp_q[$];

  // Reference model state.
  // The FSM sees the raw pin two edges late.
  // The level flips once DEB+1 consecutive observed samples disagree with it.
  bit d1, d2;
  int run;
  bit exp_level;
  bit exp_busy;

  task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cycle_cnt);
    end
  endtask

  always @(posedge clock or posedge reset) begin
    bit in_val;
    if (reset) begin
      d1 = 1'b0;
      d2 = 1'b0;
      run = 0;
      exp_level = 1'b0;
      exp_busy = 1'b0;
      exp_q.delete();
    end else begin
      cycle_cnt++;
      in_val = d2;
      d2 = d1;
      d1 = bus_main.button_raw;
      if (in_val != exp_level) begin
        run++;
        if (run == DEB + 1) begin
          exp_level = in_val;
          run = 0;
          exp_q.push_back('{is_press: in_val, cycle: cycle_cnt});
        end
      end else begin
        run = 0;
      end
      exp_busy = (run != 0);
    end
  end

  // Monitor: compares the per-cycle level/busy and pops the scoreboard whenever a pulse appears.
  always @(negedge clock) begin
    event_t e;
    check_output("level", bus_main.button_level, exp_level);
    check_output("busy", bus_main.busy, exp_busy);
    check_output("pulse_exclusive", bus_main.press_pulse & bus_main.release_pulse, 0);
    if (bus_main.press_pulse || bus_main.release_pulse) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse actual=press%0b/release%0b expected=none (cycle %0d)",
                 bus_main.press_pulse, bus_main.release_pulse, cycle_cnt);
      end else begin
        e = exp_q.pop_front();
        check_output("pulse_kind", bus_main.press_pulse, e.is_press);
        check_output("pulse_cycle", cycle_cnt, e.cycle);
      end
      if (bus_main.press_pulse) begin
        press_count++;
        last_press_cycle = cycle_cnt;
      end
      if (bus_main.release_pulse) begin
        release_count++;
        last_release_cycle = cycle_cnt;
      end
    end else if (exp_q.size() > 0 && exp_q[0].cycle <= cycle_cnt) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_pulse actual=none expected=%s at cycle %0d",
               e.is_press ? "press" : "release", e.cycle);
    end
    if (bus_big.press_pulse) big_press_count++;
  end

  task automatic apply_stimulus(bit value, int n);
    bus_main.button_raw = value;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int a;
    int prev_press;
    int prev_release;
    bit v;

    bus_main.button_raw = 1'b0;
    bus_big.button_raw  = 1'b0;
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check_output("reset_level", bus_main.button_level, 0);
    check_output("reset_press", bus_main.press_pulse, 0);
    check_output("reset_release", bus_main.release_pulse, 0);
    check_output("reset_busy", bus_main.busy, 0);
    reset = 1'b0;
    apply_stimulus(1'b0, 3);

    // Clean press, then clean release.
    a = cycle_cnt + 1;
    apply_stimulus(1'b1, 12);
    check_output("clean_press_time", last_press_cycle, a + 6);
    check_output("clean_press_count", press_count, 1);
    check_output("clean_level_high", bus_main.button_level, 1);
    a = cycle_cnt + 1;
    apply_stimulus(1'b0, 12);
    check_output("clean_release_time", last_release_cycle, a + 6);
    check_output("clean_release_count", release_count, 1);

    // Bounces that never settle long enough.
    prev_press = press_count;
    apply_stimulus(1'b1, 3);
    apply_stimulus(1'b0, 1);
    apply_stimulus(1'b1, 2);
    apply_stimulus(1'b0, 10);
    check_output("bounce_no_press", press_count, prev_press);
    check_output("bounce_level", bus_main.button_level, 0);
    check_output("bounce_busy", bus_main.busy, 0);

    // A bounce followed by a stable press counts from the last rising sample.
    apply_stimulus(1'b1, 2);
    apply_stimulus(1'b0, 1);
    a = cycle_cnt + 1;
    apply_stimulus(1'b1, 12);
    check_output("settle_press_time", last_press_cycle, a + 6);
    check_output("settle_press_count", press_count, prev_press + 1);
    apply_stimulus(1'b0, 12);

    // Asynchronous reset in PRESS_WAIT, with the button still held afterwards.
    prev_press = press_count;
    prev_release = release_count;
    bus_main.button_raw = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_output("busy_before_reset", bus_main.busy, 1);
    #1 reset = 1'b1;
    #1;
    check_output("rst_wait_busy", bus_main.busy, 0);
    check_output("rst_wait_level", bus_main.button_level, 0);
    check_output("rst_wait_press", bus_main.press_pulse, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    a = cycle_cnt + 1;
    repeat (10) @(negedge clock);
    check_output("rst_wait_repress_time", last_press_cycle, a + 6);
    check_output("rst_wait_repress_count", press_count, prev_press + 1);

    // Asynchronous reset in HELD, with the button still held afterwards.
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check_output("rst_held_level", bus_main.button_level, 0);
    check_output("rst_held_release", bus_main.release_pulse, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    a = cycle_cnt + 1;
    repeat (10) @(negedge clock);
    check_output("rst_held_repress_time", last_press_cycle, a + 6);
    check_output("rst_held_repress_count", press_count, prev_press + 2);
    check_output("rst_no_release", release_count, prev_release);

    // Random runs of varying length.
    v = 1'b0;
    for (int i = 0; i < 80; i++) begin
      v = ~v;
      apply_stimulus(v, $urandom_range(1, 8));
    end
    apply_stimulus(1'b0, 15);
    check_output("final_level", bus_main.button_level, 0);
    check_output("queue_drained", exp_q.size(), 0);

    // Default-parameter instance: a long hold stays inside the timing window.
    bus_big.button_raw = 1'b1;
    repeat (1000) @(negedge clock);
    check_output("big_no_press", big_press_count, 0);
    check_output("big_busy", bus_big.busy, 1);
    check_output("big_level", bus_big.button_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
